// File: rtl/csa_stream_accumulator_if.sv
// rtl/csa_stream_accumulator_if.sv - operand/result handshake bundle for csa_stream_accumulator
//
// Purpose: groups the operand stream (in_*) and the result handshake (out_*)
// of the carry-save stream accumulator.
// Ports (signals):
//    in_valid  1  operand beat valid          (producer -> accumulator)
//    in_ready  1  accumulator takes a beat     (accumulator -> producer)
//    in_data   W  operand                      (producer -> accumulator)
//    in_last   1  final operand of the stream  (producer -> accumulator)
//    out_valid 1  result valid, held           (accumulator -> consumer)
//    out_ready 1  consumer takes the result    (consumer -> accumulator)
//    out_sum   W  stream sum mod 2^W           (accumulator -> consumer)
// Modports: master = producer/consumer side, slave = accumulator side.
interface csa_stream_accumulator_if #(
   parameter int W = 75
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum
   );
endinterface

// File: rtl/csa_stream_accumulator.sv
// rtl/csa_stream_accumulator.sv - carry-save stream accumulator with chunked final resolve
//
// Purpose: sums a stream of W-bit operands in redundant (sum, carry) form with
// one 3:2 compressor level per accepted beat, then resolves S+C with a
// CHUNK-bit adder over NCHUNK cycles so no W-bit ripple chain is built.
// Ports:
//    clk    in   rising-edge clock
//    rst_n  in   asynchronous active-low reset
//    clear  in   synchronous abort, returns to IDLE, beats priority over all else
//    bus    slave modport of csa_stream_accumulator_if (operand stream + result)
// Latency: out_valid rises NCHUNK+1 edges after the edge taking the last beat
// (NCHUNK chunk-add edges plus one commit edge that loads out_sum).
module csa_stream_accumulator #(
   parameter int W     = 75,
   parameter int CHUNK = 25
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   csa_stream_accumulator_if.slave bus
);
   localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
   localparam int KW     = $clog2(NCHUNK + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ACC     = 2'd1;
   localparam logic [1:0] RESOLVE = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   logic [1:0]       state;
   logic             run_q;
   logic [W-1:0]     s_reg;
   logic [W-1:0]     c_reg;
   logic [W-1:0]     res;
   logic [W-1:0]     out_sum_q;
   logic [W-1:0]     maj;
   logic [KW-1:0]    k;
   logic             cy;
   logic             out_valid_q;
   logic             in_ready_int;
   logic             beat;
   int               chunk_base;
   logic [CHUNK-1:0] s_chunk;
   logic [CHUNK-1:0] c_chunk;
   logic [CHUNK:0]   csum;

   // run_q keeps in_ready low until the first edge after reset release.
   assign in_ready_int  = run_q && ((state == IDLE) || (state == ACC));
   assign beat          = bus.in_valid && in_ready_int;
   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;

   assign maj = (s_reg & c_reg) | (s_reg & bus.in_data) | (c_reg & bus.in_data);

   // Select chunk k of S and C; bits past W (narrow final chunk) read as zero.
   always_comb begin
      chunk_base = (int'(k) < NCHUNK) ? int'(k) * CHUNK : 0;
      s_chunk    = '0;
      c_chunk    = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (chunk_base + i < W) begin
            s_chunk[i] = s_reg[chunk_base + i];
            c_chunk[i] = c_reg[chunk_base + i];
         end
      end
      csum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cy};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         run_q       <= 1'b0;
         s_reg       <= '0;
         c_reg       <= '0;
         res         <= '0;
         out_sum_q   <= '0;
         k           <= '0;
         cy          <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (clear) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            k           <= '0;
            cy          <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (beat) begin
                     s_reg <= bus.in_data;
                     c_reg <= '0;
                     state <= bus.in_last ? RESOLVE : ACC;
                  end
               end
               ACC: begin
                  if (beat) begin
                     s_reg <= s_reg ^ c_reg ^ bus.in_data;
                     c_reg <= maj << 1;      // top carry falls off: mod 2^W
                     if (bus.in_last) state <= RESOLVE;
                  end
               end
               RESOLVE: begin
                  if (k == KW'(NCHUNK)) begin
                     // All chunks resolved: commit so out_sum is stable in DONE.
                     out_sum_q   <= res;
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                     k           <= '0;
                     cy          <= 1'b0;
                  end else begin
                     for (int i = 0; i < CHUNK; i++) begin
                        if (chunk_base + i < W) res[chunk_base + i] <= csum[i];
                     end
                     cy <= csum[CHUNK];     // final chunk's carry is never consumed
                     k  <= k + 1'b1;
                  end
               end
               default: begin
                  if (bus.out_ready) begin
                     out_valid_q <= 1'b0;
                     state       <= IDLE;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb/tb_csa_stream_accumulator.sv - self-checking bench for csa_stream_accumulator
module tb_csa_stream_accumulator;
   localparam int WA = 75;
   localparam int CA = 25;
   localparam int WB = 13;
   localparam int CB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          sel = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b0;
   logic [WA-1:0] in_data = '0;
   logic [WA-1:0] mask;
   logic [WA-1:0] d;
   logic [WA-1:0] ref_sum;
   int            len;
   int            n_assert = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   csa_stream_accumulator_if #(.W(WA)) ifa ();
   csa_stream_accumulator_if #(.W(WB)) ifb ();

   assign ifa.in_valid  = in_valid & ~sel;
   assign ifa.in_data   = in_data;
   assign ifa.in_last   = in_last;
   assign ifa.out_ready = out_ready & ~sel;
   assign ifb.in_valid  = in_valid & sel;
   assign ifb.in_data   = in_data[WB-1:0];
   assign ifb.in_last   = in_last;
   assign ifb.out_ready = out_ready & sel;

   csa_stream_accumulator #(.W(WA), .CHUNK(CA)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifa.slave)
   );
   csa_stream_accumulator #(.W(WB), .CHUNK(CB)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifb.slave)
   );

   wire          cur_in_ready  = sel ? ifb.in_ready : ifa.in_ready;
   wire          cur_out_valid = sel ? ifb.out_valid : ifa.out_valid;
   wire [WA-1:0] cur_sum       = sel ? WA'(ifb.out_sum) : ifa.out_sum;

   task automatic chk(input string tag, input logic [WA-1:0] obs, input logic [WA-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_beat(input logic [WA-1:0] data, input logic last, input int gap);
      int n;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      n = 0;
      while (!cur_in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("beat_accept", cur_in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic get_result(input string tag, input logic [WA-1:0] exp, input int delay);
      int n;
      out_ready = 1'b0;
      n = 0;
      while (!cur_out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, cur_out_valid, 1);
      repeat (delay) @(negedge clk);
      chk(tag, cur_sum, exp);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      // Reset values
      #1;
      chk("rst_out_valid", ifa.out_valid, 0);
      chk("rst_out_sum", ifa.out_sum, 0);
      chk("rst_in_ready", ifa.in_ready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single beat, latency
      send_beat(WA'(5), 1'b1, 0);
      repeat (3) @(negedge clk);
      chk("lat_edge3", cur_out_valid, 0);
      @(negedge clk);
      chk("lat_edge4", cur_out_valid, 1);
      get_result("single5", WA'(5), 0);

      // Wrap modulo 2^75
      send_beat({WA{1'b1}}, 1'b0, 0);
      send_beat(WA'(1), 1'b0, 0);
      send_beat(WA'(1), 1'b1, 0);
      get_result("wrap", WA'(1), 0);

      // 3+5+7+9 with result backpressure and a pending beat
      send_beat(WA'(3), 1'b0, 0);
      send_beat(WA'(5), 1'b0, 0);
      send_beat(WA'(7), 1'b0, 0);
      send_beat(WA'(9), 1'b1, 0);
      for (int i = 0; i < 20 && !cur_out_valid; i++) @(negedge clk);
      chk("bp_valid", cur_out_valid, 1);
      in_valid = 1'b1;
      in_data  = WA'(100);
      in_last  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_sum_held", cur_sum, WA'(24));
         chk("bp_in_ready", cur_in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_idle_valid", cur_out_valid, 0);
      chk("bp_idle_ready", cur_in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("bp_beat_taken", cur_in_ready, 0);
      get_result("bp_next", WA'(100), 0);

      // clear mid-stream beats a coincident last beat
      send_beat(WA'(50), 1'b0, 0);
      send_beat(WA'(60), 1'b0, 0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = WA'(999);
      in_last  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("clear_idle_ready", cur_in_ready, 1);
      chk("clear_out_valid", cur_out_valid, 0);
      send_beat(WA'(7), 1'b0, 0);
      send_beat(WA'(8), 1'b1, 0);
      get_result("after_clear", WA'(15), 0);

      // Reset pulse mid-RESOLVE
      send_beat(WA'(1000), 1'b1, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", ifa.out_valid, 0);
      chk("arst_out_sum", ifa.out_sum, 0);
      chk("arst_in_ready", ifa.in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send_beat(WA'(1), 1'b0, 0);
      send_beat(WA'(2), 1'b1, 0);
      get_result("after_arst", WA'(3), 0);

      // Random streams against a mod-2^W sum, on both configurations
      for (int cfg = 0; cfg < 2; cfg++) begin
         sel  = (cfg == 1);
         mask = '1;
         if (cfg == 1) mask = (WA'(1) << WB) - WA'(1);
         @(negedge clk);
         for (int s = 0; s < 500; s++) begin
            len     = int'($urandom_range(1, 16));
            ref_sum = '0;
            for (int b = 0; b < len; b++) begin
               d       = WA'({$urandom, $urandom, $urandom}) & mask;
               ref_sum = (ref_sum + d) & mask;
               send_beat(d, (b == len - 1), int'($urandom_range(0, 2)));
            end
            get_result(cfg == 0 ? "rand_w75" : "rand_w13", ref_sum, int'($urandom_range(0, 3)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
